// File: rtl/main_memory_pkg.sv
// Shared widths, the buffered-entry record and the block-to-word mapping for the
// main-memory write buffer.
package main_memory_pkg;

  localparam int BLOCK_ADDR_W    = 13;
  localparam int WORD_ADDR_W     = 15;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;

  typedef struct packed {
    logic [BLOCK_ADDR_W-1:0] addr;
    logic [BLOCK_W-1:0]      data;
  } entry_t;

  // Word offset 0 lives in the most significant bits of the block.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] data,
                                                   input logic [1:0]         beat);
    logic [WORD_W-1:0] w;
    case (beat)
      2'd0:    w = data[127:96];
      2'd1:    w = data[95:64];
      2'd2:    w = data[63:32];
      2'd3:    w = data[31:0];
      default: w = {WORD_W{1'b0}};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/main_memory_write_buffer_store.sv
// Entry array with valid bits and youngest-match search; the coalescing search
// port exists only when WB_COALESCE_EN is defined.
module write_buffer_store
  import main_memory_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic                    wr_alloc,
  input  logic [PTR_W-1:0]        wr_idx,
  input  entry_t                  wr_entry,
  input  logic                    clr_en,
  input  logic [PTR_W-1:0]        clr_idx,
  input  logic [PTR_W-1:0]        head_idx,
  input  logic [BLOCK_ADDR_W-1:0] lookup_addr,
  output logic                    lookup_hit,
  output logic [BLOCK_W-1:0]      lookup_data,
`ifdef WB_COALESCE_EN
  input  logic [BLOCK_ADDR_W-1:0] co_addr,
  output logic                    co_hit,
  output logic [PTR_W-1:0]        co_idx,
`endif
  output entry_t                  head_entry
);

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [PTR_W:0]   fwd_s;
`ifdef WB_COALESCE_EN
  logic [PTR_W:0]   co_s;
`endif

  // Walk oldest to youngest from head so the last match found is the youngest.
  function automatic logic [PTR_W:0] find_youngest(input logic [BLOCK_ADDR_W-1:0] addr,
                                                   input logic                    incl_head);
    logic [PTR_W:0]   r;
    logic [PTR_W-1:0] idx;
    r = {(PTR_W+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_idx + PTR_W'(i);
      if (valid_q[idx] && (entries_q[idx].addr == addr) && (incl_head || (i != 0))) begin
        r = {1'b1, idx};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Next array state: retire the popped entry, then apply the tail write or overwrite.
  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    if (clr_en) begin
      valid_d[clr_idx] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (wr_en) begin
      entries_d[wr_idx] = wr_entry;
      if (wr_alloc) begin
        valid_d[wr_idx] = 1'b1;
      end else begin
        valid_d = valid_d;
      end
    end else begin
      entries_d = entries_d;
    end
  end

  // Entry storage and valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= {(BLOCK_ADDR_W+BLOCK_W){1'b0}};
      end
      valid_q <= {DEPTH{1'b0}};
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
    end
  end

  // Forwarding lookup, optional coalescing lookup and the head view for draining.
  always_comb begin
    fwd_s      = find_youngest(lookup_addr, 1'b1);
    lookup_hit = fwd_s[PTR_W];
    if (fwd_s[PTR_W]) begin
      lookup_data = entries_q[fwd_s[PTR_W-1:0]].data;
    end else begin
      lookup_data = {BLOCK_W{1'b0}};
    end
`ifdef WB_COALESCE_EN
    co_s   = find_youngest(co_addr, 1'b0);
    co_hit = co_s[PTR_W];
    co_idx = co_s[PTR_W-1:0];
`endif
    head_entry = entries_q[head_idx];
  end

endmodule

// File: rtl/main_memory_write_buffer.sv
// Write-back buffer: queues 128-bit evicted blocks and drains each as four
// 32-bit word writes. Define WB_COALESCE_EN to merge pushes into queued entries.
module main_memory_write_buffer
  import main_memory_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [BLOCK_ADDR_W-1:0] inAddress,
  input  logic [BLOCK_W-1:0]      inData,
  output logic                    memWriteEn,
  output logic [WORD_ADDR_W-1:0]  memAddress,
  output logic [WORD_W-1:0]       memWriteData,
  input  logic [BLOCK_ADDR_W-1:0] lookupAddress,
  output logic                    lookupHit,
  output logic [BLOCK_W-1:0]      lookupData,
  output logic                    empty
);

  localparam int             PTR_W  = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ZERO_C = {(PTR_W+1){1'b0}};

  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [1:0]       beat_q, beat_d;
  logic             push_s, pop_s, alloc_s;
  logic [PTR_W-1:0] wr_idx_s;
  entry_t           head_entry_s;
`ifdef WB_COALESCE_EN
  logic             co_hit_s;
  logic [PTR_W-1:0] co_idx_s;
`endif

  write_buffer_store #(.DEPTH(DEPTH)) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (push_s),
    .wr_alloc    (alloc_s),
    .wr_idx      (wr_idx_s),
    .wr_entry    ({inAddress, inData}),
    .clr_en      (pop_s),
    .clr_idx     (head_q),
    .head_idx    (head_q),
    .lookup_addr (lookupAddress),
    .lookup_hit  (lookupHit),
    .lookup_data (lookupData),
`ifdef WB_COALESCE_EN
    .co_addr     (inAddress),
    .co_hit      (co_hit_s),
    .co_idx      (co_idx_s),
`endif
    .head_entry  (head_entry_s)
  );

  // Handshake, pointer/count/beat update and memory-port drive.
  always_comb begin
    pop_s = (count_q != ZERO_C) && (beat_q == 2'd3);
`ifdef WB_COALESCE_EN
    inReady = (count_q != FULL_C) || co_hit_s;
    push_s  = inValid && inReady;
    alloc_s = push_s && !co_hit_s;
    if (co_hit_s) begin
      wr_idx_s = co_idx_s;
    end else begin
      wr_idx_s = tail_q;
    end
`else
    inReady  = (count_q != FULL_C);
    push_s   = inValid && inReady;
    alloc_s  = push_s;
    wr_idx_s = tail_q;
`endif
    if (alloc_s) begin
      tail_d = tail_q + PTR_W'(1'b1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PTR_W'(1'b1);
    end else begin
      head_d = head_q;
    end
    case ({alloc_s, pop_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1'b1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1'b1);
      default: count_d = count_q;
    endcase
    empty = (count_q == ZERO_C);
    if (count_q != ZERO_C) begin
      beat_d       = beat_q + 2'd1;
      memWriteEn   = 1'b1;
      memAddress   = {head_entry_s.addr, beat_q};
      memWriteData = block_word(head_entry_s.data, beat_q);
    end else begin
      beat_d       = 2'd0;
      memWriteEn   = 1'b0;
      memAddress   = {WORD_ADDR_W{1'b0}};
      memWriteData = {WORD_W{1'b0}};
    end
  end

  // Queue pointers, occupancy and drain beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= ZERO_C;
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      beat_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_main_memory_write_buffer.sv
// Scoreboard bench: the driver records accepted blocks in a pending-block queue,
// and a negedge monitor checks every output against that queue.
module tb_main_memory_write_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [12:0]  addr;
    logic [127:0] data;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [12:0]  inAddress = 13'd0;
  logic [127:0] inData = 128'd0;
  logic         memWriteEn;
  logic [14:0]  memAddress;
  logic [31:0]  memWriteData;
  logic [12:0]  lookupAddress = 13'd0;
  logic         lookupHit;
  logic [127:0] lookupData;
  logic         empty;

  int   vectors = 0;
  int   errors  = 0;
  ent_t pend[$];
  int   mbeat = 0;
  logic rdy_exp = 1'b0;
  logic co_hit_exp = 1'b0;
  int   co_idx_exp = 0;

  main_memory_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .inAddress(inAddress), .inData(inData), .memWriteEn(memWriteEn),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .lookupAddress(lookupAddress), .lookupHit(lookupHit),
    .lookupData(lookupData), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] d, input int b);
    logic [127:0] t;
    t = d >> (32 * (3 - b));
    return t[31:0];
  endfunction

  // Monitor: compare outputs with the pending queue, then advance the drain model.
  always @(negedge clk) begin
    logic         hit;
    logic [127:0] dat;
    int           co_i;
    logic         popped;
    if (!rst_n) begin
      chk("rst_inReady", inReady, 1);
      chk("rst_memWriteEn", memWriteEn, 0);
      chk("rst_memAddress", memAddress, 0);
      chk("rst_memWriteData", memWriteData, 0);
      chk("rst_lookupHit", lookupHit, 0);
      chk("rst_lookupData", lookupData, 0);
      chk("rst_empty", empty, 1);
      pend.delete();
      mbeat = 0;
      rdy_exp = 1'b0;
      co_hit_exp = 1'b0;
    end else begin
      hit = 1'b0;
      dat = 128'd0;
      foreach (pend[i]) begin
        if (pend[i].addr == lookupAddress) begin
          hit = 1'b1;
          dat = pend[i].data;
        end
      end
      co_i = -1;
`ifdef WB_COALESCE_EN
      for (int i = 1; i < pend.size(); i++) begin
        if (pend[i].addr == inAddress) co_i = i;
      end
`endif
      rdy_exp = (pend.size() != DEPTH) || (co_i >= 0);
      chk("inReady", inReady, rdy_exp);
      chk("empty", empty, pend.size() == 0);
      chk("lookupHit", lookupHit, hit);
      chk("lookupData", lookupData, dat);
      if (pend.size() != 0) begin
        chk("memWriteEn", memWriteEn, 1);
        chk("memAddress", memAddress, int'(pend[0].addr) * 4 + mbeat);
        chk("memWriteData", memWriteData, word_of(pend[0].data, mbeat));
      end else begin
        chk("memWriteEn_idle", memWriteEn, 0);
        chk("memAddress_idle", memAddress, 0);
        chk("memWriteData_idle", memWriteData, 0);
      end
      popped = 1'b0;
      if (pend.size() != 0) begin
        mbeat++;
        if (mbeat == 4) begin
          void'(pend.pop_front());
          mbeat = 0;
          popped = 1'b1;
        end
      end
      co_hit_exp = (co_i >= 0);
      co_idx_exp = popped ? co_i - 1 : co_i;
    end
  end

  // One clock of stimulus; an accepted block is recorded in the scoreboard at the edge.
  task automatic step(input logic v, input logic [12:0] a, input logic [127:0] d, output logic took);
    ent_t e;
    inValid = v;
    inAddress = a;
    inData = d;
    @(posedge clk);
    took = v && rdy_exp && rst_n;
    if (took) begin
      if (co_hit_exp) begin
        e = pend[co_idx_exp];
        e.data = d;
        pend[co_idx_exp] = e;
      end else begin
        e.addr = a;
        e.data = d;
        pend.push_back(e);
      end
    end
    #1;
    inValid = 1'b0;
  endtask

  task automatic push(input logic [12:0] a, input logic [127:0] d);
    logic took;
    int n;
    took = 1'b0;
    n = 0;
    while (!took && n < 50) begin
      step(1'b1, a, d, took);
      n++;
    end
    vectors++;
    if (!took) begin
      errors++;
      $display("FAIL push_timeout addr %h: not accepted within 50 cycles, required acceptance", a);
    end
  endtask

  task automatic idle(input int n);
    logic t;
    repeat (n) step(1'b0, 13'd0, 128'd0, t);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [12:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 13'h0010;
      1: return 13'h0011;
      2: return 13'h1FFF;
      default: return 13'($urandom);
    endcase
  endfunction

  initial begin
    logic t;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    // single block, word order and addresses 0x14..0x17
    push(13'h0005, 128'h0000000A_0000000B_0000000C_0000000D);
    idle(6);
    // forwarding of a block across all four beats
    lookupAddress = 13'h1FFF;
    push(13'h1FFF, rnd128());
    idle(6);
    // five back-to-back pushes: full stall and bubble-free drain
    for (int i = 0; i < 5; i++) push(13'(16'h0100 + i), rnd128());
    idle(25);
    // duplicate address behind a draining head
    lookupAddress = 13'h0010;
    push(13'h0020, rnd128());
    push(13'h0010, 128'h11111111_22222222_33333333_44444444);
    push(13'h0010, 128'h55555555_66666666_77777777_88888888);
    idle(15);
    // reset during beat 2 of a three-deep queue
    push(13'h0030, rnd128());
    push(13'h0031, rnd128());
    push(13'h0032, rnd128());
    rst_n = 1'b0;
    #1;
    chk("async_rst_memWriteEn", memWriteEn, 0);
    chk("async_rst_empty", empty, 1);
    idle(2);
    rst_n = 1'b1;
    idle(8);
    // lookup of a block pushed into an empty buffer in the same cycle
    lookupAddress = 13'h0777;
    push(13'h0777, rnd128());
    idle(6);
    // randomized traffic with frequent address reuse
    for (int c = 0; c < 1500; c++) begin
      lookupAddress = pick_addr();
      step($urandom_range(0, 3) != 0, pick_addr(), rnd128(), t);
    end
    idle(25);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
